// File: rtl/sky130_fd_io__sio_pair_seq.sv
// Control sequencer for the two-pad SIO macro: power-up enable ordering, then held configuration updates.
// Optional: define SIO_SEQ_IN_SYNC_EN to put a two-flop synchronizer on the pad inputs.
module sky130_fd_io__sio_pair_seq #(
  parameter int PWR_CYC  = 16,
  parameter int HOLD_CYC = 4,
  parameter int REF_CYC  = 64,
  parameter int CNT_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_b,
  input  logic        i_cfg_valid,
  output logic        o_cfg_ready,
  input  logic [18:0] i_cfg_data,
  output logic        o_done,
  output logic        o_enable_h,
  output logic        o_enable_vdda_h,
  output logic [1:0]  o_hld_h_n,
  output logic        o_hld_h_n_refgen,
  output logic [2:0]  o_dm0,
  output logic [2:0]  o_dm1,
  output logic [1:0]  o_vtrip_sel,
  output logic [1:0]  o_vref_sel,
  output logic [1:0]  o_ibuf_sel,
  output logic [1:0]  o_vreg_en,
  output logic [1:0]  o_slow,
  output logic [2:0]  o_voh_sel,
  input  logic [1:0]  i_in,
  output logic [1:0]  o_in_sync
);

  typedef enum logic [2:0] {
    S_PWR_EN, S_PWR_VDDA, S_IDLE, S_HOLD, S_APPLY, S_SETTLE, S_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] L_PWR      = CNT_W'(PWR_CYC);
  localparam logic [CNT_W-1:0] L_PWR_M1   = CNT_W'(PWR_CYC - 1);
  localparam logic [CNT_W-1:0] L_HOLD_M1  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] L_REF_M1   = CNT_W'(REF_CYC - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_ref_chg;
  logic             w_ref_chg_next;
  logic             w_xfer;
  logic [18:0]      r_shadow;

  logic             r_enable_h, r_enable_vdda_h, r_cfg_ready, r_done;
  logic [1:0]       r_hld_h_n;
  logic             r_hld_h_n_refgen;
  logic [2:0]       r_dm0, r_dm1, r_voh_sel;
  logic [1:0]       r_vtrip_sel, r_vref_sel, r_ibuf_sel, r_vreg_en, r_slow;

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt + 1'b1;
    w_ref_chg_next = r_ref_chg;
    w_xfer         = 1'b0;
    case (r_state)
      // The cycle spent in reset also sits in PWR_EN, so this state compares one higher.
      S_PWR_EN: if (r_cnt == L_PWR) begin
        w_state_next = S_PWR_VDDA;
        w_cnt_next   = '0;
      end
      S_PWR_VDDA: if (r_cnt == L_PWR_M1) begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
      S_IDLE: begin
        w_cnt_next = '0;
        if (i_cfg_valid && r_cfg_ready) begin
          w_xfer         = 1'b1;
          w_state_next   = S_HOLD;
          w_ref_chg_next = (i_cfg_data[14:8] != {r_ibuf_sel, r_voh_sel, r_vref_sel});
        end
      end
      S_HOLD: if (r_cnt == L_HOLD_M1) begin
        w_state_next = S_APPLY;
        w_cnt_next   = '0;
      end
      S_APPLY: begin
        w_state_next = S_SETTLE;
        w_cnt_next   = '0;
      end
      S_SETTLE: if (r_cnt == (r_ref_chg ? L_REF_M1 : L_HOLD_M1)) begin
        w_state_next = S_RELEASE;
        w_cnt_next   = '0;
      end
      S_RELEASE: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = S_PWR_EN;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they stay glitch-free on the HV pins.
  always_ff @(posedge i_clk) begin
    if (!i_reset_b) begin
      r_state          <= S_PWR_EN;
      r_cnt            <= '0;
      r_ref_chg        <= 1'b0;
      r_shadow         <= '0;
      r_enable_h       <= 1'b0;
      r_enable_vdda_h  <= 1'b0;
      r_cfg_ready      <= 1'b0;
      r_done           <= 1'b0;
      r_hld_h_n        <= 2'b00;
      r_hld_h_n_refgen <= 1'b0;
      r_dm0            <= '0;
      r_dm1            <= '0;
      r_vtrip_sel      <= '0;
      r_vref_sel       <= '0;
      r_voh_sel        <= '0;
      r_ibuf_sel       <= '0;
      r_vreg_en        <= '0;
      r_slow           <= '0;
    end else begin
      r_state         <= w_state_next;
      r_cnt           <= w_cnt_next;
      r_ref_chg       <= w_ref_chg_next;
      r_enable_h      <= 1'b1;
      r_enable_vdda_h <= r_enable_vdda_h | (w_state_next == S_PWR_VDDA);
      r_cfg_ready     <= (w_state_next == S_IDLE);
      r_done          <= (w_state_next == S_RELEASE);
      if (w_xfer) r_shadow <= i_cfg_data;
      if (w_state_next == S_HOLD) begin
        r_hld_h_n <= 2'b00;
        if (w_ref_chg_next) r_hld_h_n_refgen <= 1'b0;
      end else if (w_state_next == S_RELEASE) begin
        r_hld_h_n        <= 2'b11;
        r_hld_h_n_refgen <= 1'b1;
      end
      if (r_state == S_APPLY) begin
        r_dm0       <= r_shadow[2:0];
        r_dm1       <= r_shadow[5:3];
        r_vtrip_sel <= r_shadow[7:6];
        r_vref_sel  <= r_shadow[9:8];
        r_voh_sel   <= r_shadow[12:10];
        r_ibuf_sel  <= r_shadow[14:13];
        r_vreg_en   <= r_shadow[16:15];
        r_slow      <= r_shadow[18:17];
      end
    end
  end

  assign o_cfg_ready      = r_cfg_ready;
  assign o_done           = r_done;
  assign o_enable_h       = r_enable_h;
  assign o_enable_vdda_h  = r_enable_vdda_h;
  assign o_hld_h_n        = r_hld_h_n;
  assign o_hld_h_n_refgen = r_hld_h_n_refgen;
  assign o_dm0            = r_dm0;
  assign o_dm1            = r_dm1;
  assign o_vtrip_sel      = r_vtrip_sel;
  assign o_vref_sel       = r_vref_sel;
  assign o_voh_sel        = r_voh_sel;
  assign o_ibuf_sel       = r_ibuf_sel;
  assign o_vreg_en        = r_vreg_en;
  assign o_slow           = r_slow;

`ifdef SIO_SEQ_IN_SYNC_EN
  logic [1:0] r_in_meta, r_in_sync;

  always_ff @(posedge i_clk) begin
    if (!i_reset_b) begin
      r_in_meta <= 2'b00;
      r_in_sync <= 2'b00;
    end else begin
      r_in_meta <= i_in;
      r_in_sync <= r_in_meta;
    end
  end

  assign o_in_sync = r_in_sync;
`else
  assign o_in_sync = i_in;
`endif

endmodule

// File: tb/tb_sky130_fd_io__sio_pair_seq.sv
// Randomized bench for sky130_fd_io__sio_pair_seq; expected timing derived arithmetically from the request rules.
module tb_sky130_fd_io__sio_pair_seq;

  localparam int PWR_CYC  = 16;
  localparam int HOLD_CYC = 4;
  localparam int REF_CYC  = 64;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        cfg_valid;
  logic [18:0] cfg_data;
  logic [1:0]  in_pad;
  logic        cfg_ready, done, enable_h, enable_vdda_h, hld_refgen;
  logic [1:0]  hld, vtrip_sel, vref_sel, ibuf_sel, vreg_en, slow, in_sync;
  logic [2:0]  dm0, dm1, voh_sel;
  logic [18:0] ctrl;

  int n_pass  = 0;
  int n_total = 0;

  logic [18:0] exp_ctrl;
  logic [1:0]  exp_hld;
  logic        exp_ref;

  always #5 clk = ~clk;

  assign ctrl = {slow, vreg_en, ibuf_sel, voh_sel, vref_sel, vtrip_sel, dm1, dm0};

  sky130_fd_io__sio_pair_seq dut (
    .i_clk            (clk),
    .i_reset_b        (reset_b),
    .i_cfg_valid      (cfg_valid),
    .o_cfg_ready      (cfg_ready),
    .i_cfg_data       (cfg_data),
    .o_done           (done),
    .o_enable_h       (enable_h),
    .o_enable_vdda_h  (enable_vdda_h),
    .o_hld_h_n        (hld),
    .o_hld_h_n_refgen (hld_refgen),
    .o_dm0            (dm0),
    .o_dm1            (dm1),
    .o_vtrip_sel      (vtrip_sel),
    .o_vref_sel       (vref_sel),
    .o_ibuf_sel       (ibuf_sel),
    .o_vreg_en        (vreg_en),
    .o_slow           (slow),
    .o_voh_sel        (voh_sel),
    .i_in             (in_pad),
    .o_in_sync        (in_sync)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want)
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    else
      n_pass++;
  endtask

  // Reset for three edges, then walk the power-up ramp and check enable/ready timing.
  task automatic power_up();
    reset_b   = 1'b0;
    cfg_valid = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_outputs", {enable_h, enable_vdda_h, cfg_ready, done, hld, hld_refgen, ctrl}, 32'd0);
    end
    reset_b = 1'b1;
    for (int k = 1; k <= 2 * PWR_CYC + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("pwr_enable_h", enable_h, 1);
      chk("pwr_enable_vdda_h", enable_vdda_h, (k >= PWR_CYC + 1));
      chk("pwr_cfg_ready", cfg_ready, (k >= 2 * PWR_CYC + 1));
      chk("pwr_rest", {done, hld, hld_refgen, ctrl}, 32'd0);
    end
    exp_ctrl = '0;
    exp_hld  = 2'b00;
    exp_ref  = 1'b0;
    $display("power-up complete at %0t", $time);
  endtask

  // Issue one request; called at a negedge. abort_at>0 returns after that cycle without finishing.
  task automatic run_req(input logic [18:0] data, input bit busy_valid, input int abort_at,
                         input bit after_req);
    int   waited = 0;
    bit   refchg;
    int   settle, last;
    logic [18:0] want_ctrl;
    while (!cfg_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!cfg_ready) begin
      chk("ready_wait", cfg_ready, 1);
      return;
    end
    if (after_req) chk("b2b_accept_cycle", waited, 1);
    cfg_valid = 1'b1;
    cfg_data  = data;
    refchg = (data[14:8] != exp_ctrl[14:8]);
    settle = refchg ? REF_CYC : HOLD_CYC;
    last   = HOLD_CYC + settle + 2;
    $display("req data=%h refchg=%0d settle=%0d busy_valid=%0d", data, refchg, settle, busy_valid);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy_valid) cfg_data = 19'($urandom);
      else            cfg_valid = 1'b0;
      want_ctrl = (c >= HOLD_CYC + 2) ? data : exp_ctrl;
      chk("req_ctrl", ctrl, want_ctrl);
      chk("req_hld", hld, (c == last) ? 2'b11 : 2'b00);
      chk("req_hld_refgen", hld_refgen, (c == last) ? 1'b1 : (refchg ? 1'b0 : exp_ref));
      chk("req_done", done, (c == last));
      chk("req_ready_busy", cfg_ready, 0);
      if (c == abort_at) return;
    end
    exp_ctrl = data;
    exp_hld  = 2'b11;
    exp_ref  = 1'b1;
  endtask

  initial begin
    logic [18:0] d;
    logic [1:0]  v1, v2, pat;
    reset_b   = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    in_pad    = 2'b00;
    @(negedge clk);

    power_up();

    // No-change request, pad-only change, then refgen change.
    run_req(19'd0, 1'b0, 0, 1'b0);
    run_req({13'd0, 3'b001, 3'b110}, 1'b0, 0, 1'b1);
    d = '0;
    d[9:8]   = 2'b10;
    d[12:10] = 3'b011;
    run_req(d, 1'b0, 0, 1'b1);

    // CFG_VALID held through busy sequences, each followed by an immediate second transfer.
    for (int i = 0; i < 4; i++) begin
      run_req(19'($urandom), 1'b1, 0, 1'b1);
      run_req(19'($urandom), 1'b0, 0, 1'b1);
    end

    // Reset while in SETTLE of a refgen-changing request.
    d = 19'($urandom);
    d[9:8] = ~exp_ctrl[9:8];
    run_req(d, 1'b0, HOLD_CYC + 4, 1'b1);
    power_up();
    run_req(19'($urandom), 1'b0, 0, 1'b0);

    // Pad input path: 01 then 10, then random patterns.
    @(negedge clk);
    v1 = in_pad;
    v2 = in_pad;
    for (int i = 0; i < 16; i++) begin
`ifdef SIO_SEQ_IN_SYNC_EN
      chk("in_sync_lag2", in_sync, v2);
`else
      chk("in_sync_pass", in_sync, v1);
`endif
      pat = (i == 0) ? 2'b01 : (i == 3) ? 2'b10 : (i > 5) ? 2'($urandom) : in_pad;
      in_pad = pat;
`ifndef SIO_SEQ_IN_SYNC_EN
      #1;
      chk("in_sync_same_cycle", in_sync, pat);
`endif
      @(posedge clk);
      v2 = v1;
      v1 = in_pad;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sky130_fd_io__sio_pair_seq.md
# sky130_fd_io__sio_pair_seq

Core-side control sequencer that drives the control pins of the two-pad SIO macro (pad pair plus shared reference generator). It runs the power-up enable ordering, then accepts pad-configuration requests over a valid/ready handshake and applies each one under hold. The sequence is: latch the pads, update DM/VTRIP/VREF/VOH/IBUF/VREG/SLOW, wait for the reference to settle, release the hold. It sits between the chip's GPIO configuration logic and the SIO macro instance.

## Interface
- PWR_CYC, 16: cycles between ENABLE_H rise and ENABLE_VDDA_H rise, and between that rise and IDLE.
- HOLD_CYC, 4: cycles in HOLD before APPLY; also the settle length when no refgen field changes.
- REF_CYC, 64: settle length when VREF_SEL, VOH_SEL or IBUF_SEL changes.
- CNT_W, 8: counter width. All cycle parameters are in the range 1 .. 2^CNT_W-1.
- CLK  in  1  sole clock.
- RESET_B  in  1  reset, synchronous and active-low.
- CFG_VALID  in  1  configuration request valid.
- CFG_READY  out  1  sequencer accepts a request. High only in IDLE.
- CFG_DATA  in  19  field map: [2:0] DM0, [5:3] DM1, [7:6] VTRIP_SEL, [9:8] VREF_SEL, [12:10] VOH_SEL, [14:13] IBUF_SEL, [16:15] VREG_EN, [18:17] SLOW.
- DONE  out  1  one-cycle pulse when a request has been fully applied.
- ENABLE_H, ENABLE_VDDA_H  out  1 each  macro enables.
- HLD_H_N  out  2  per-pad hold, active-low.
- HLD_H_N_REFGEN  out  1  refgen hold, active-low.
- DM0, DM1  out  3 each  pad drive modes.
- VTRIP_SEL, VREF_SEL, IBUF_SEL, VREG_EN, SLOW  out  2 each  macro controls. VREF_SEL, IBUF_SEL and VREG_EN go to the pad pair; the refgen copies of IBUF_SEL/VREG_EN are driven from bit 0.
- VOH_SEL  out  3  output-high reference select.
- IN  in  2  pad-pair core inputs.
- IN_SYNC  out  2  core-usable pad inputs (see Configuration).

## Operation
- States: PWR_EN, PWR_VDDA, IDLE, HOLD, APPLY, SETTLE, RELEASE.
- Reset values (RESET_B=0 at a CLK edge):
  - state PWR_EN, counter 0.
  - All outputs 0: ENABLE_H, ENABLE_VDDA_H, HLD_H_N=2'b00, HLD_H_N_REFGEN, DM0/DM1=3'b000, all other control buses, CFG_READY, DONE.
  - Pads are held and disabled.
- Power-up:
  - PWR_EN: ENABLE_H=1, count PWR_CYC cycles, then go to PWR_VDDA.
  - PWR_VDDA: ENABLE_VDDA_H=1, count PWR_CYC cycles, then go to IDLE.
  - Enables then stay 1 until reset.
- IDLE:
  - CFG_READY=1.
  - Transfer occurs when CFG_VALID && CFG_READY at a CLK edge. CFG_DATA is captured into a shadow register.
  - The refgen-change flag is computed at capture: shadow VREF_SEL/VOH_SEL/IBUF_SEL differ from the current outputs.
  - Next state is HOLD.
- HOLD:
  - HLD_H_N=2'b00; HLD_H_N_REFGEN=0 if the refgen-change flag is set, else unchanged.
  - Lasts HOLD_CYC cycles.
- APPLY: one cycle. All control outputs load from the shadow at the end of the cycle.
- SETTLE: lasts REF_CYC cycles if the refgen-change flag is set, else HOLD_CYC. Holds are still asserted.
- RELEASE:
  - One cycle. HLD_H_N=2'b11, HLD_H_N_REFGEN=1, DONE=1.
  - Next state is IDLE.
- The first request after reset runs the full HOLD sequence, even though the holds are already low.
- CFG_VALID outside IDLE is ignored; CFG_DATA is sampled only on transfer.
- Back-to-back requests: the next request can be accepted in the cycle after RELEASE at the earliest.

## Timing
- Power-up: ENABLE_H=1 in the first cycle after reset deasserts. ENABLE_VDDA_H rises PWR_CYC cycles later. CFG_READY rises 2*PWR_CYC cycles after ENABLE_H.
- Request latency: with the transfer edge as cycle 0, cycles 1..HOLD_CYC are HOLD, cycle HOLD_CYC+1 is APPLY, then N SETTLE cycles, then RELEASE.
  - New control values are visible from cycle HOLD_CYC+2.
  - DONE and the hold release occur in cycle HOLD_CYC+N+2.
- Control outputs never change while HLD_H_N=2'b11, except via reset.
- Reset mid-sequence takes precedence at that edge. All outputs return to their reset values in the next cycle, the shadow is discarded, and power-up restarts.

## Configuration
- SIO_SEQ_IN_SYNC_EN defined: IN passes through a two-flop synchronizer per bit. IN_SYNC lags IN by 2 CLK edges, and the synchronizer flops reset to 0.
- SIO_SEQ_IN_SYNC_EN undefined: IN_SYNC = IN combinationally, with zero latency and no flops.

## Test plan
- Power-up, PWR_CYC=16: reset 3 cycles, release. Required: ENABLE_H=1 the next cycle, ENABLE_VDDA_H=1 16 cycles later, CFG_READY=1 32 cycles after ENABLE_H. All other outputs stay 0.
- Pad-only change, HOLD_CYC=4: CFG_DATA DM0=3'b110, DM1=3'b001, refgen fields 0. Required: HLD_H_N=00 for 4+1+4 cycles, HLD_H_N_REFGEN stays 1, DM0/DM1 update in cycle 6, DONE pulses in cycle 10.
- Refgen change, REF_CYC=64: VREF_SEL=2'b10, VOH_SEL=3'b011. Required: HLD_H_N_REFGEN=0 from cycle 1, DONE in cycle 4+64+2=70, outputs match CFG_DATA.
- CFG_VALID held high through a busy sequence with changing CFG_DATA. Required: only the value present at the IDLE transfer is applied, CFG_READY=0 from cycle 1 through RELEASE, and the second transfer occurs in the cycle after DONE.
- Reset asserted in SETTLE. Required: the next cycle shows all outputs 0, DONE never pulses, and power-up repeats.
- Build with and without SIO_SEQ_IN_SYNC_EN, toggling IN=2'b01 to 2'b10. Required: IN_SYNC follows after 2 edges with the macro, and in the same cycle without it.
